merlin_prefetch_ctrl: RTL and testbench

MERLIN_PREFETCH_CTRL -- requirements
Module: merlin_prefetch_ctrl

---
 rtl/merlin_prefetch_ctrl.sv | 117 +++++++++++
 tb/tb_merlin_prefetch_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/merlin_prefetch_ctrl.sv
// Instruction prefetch controller: issues word-aligned fetches, writes in-order
// responses into a downstream FIFO and discards responses made stale by a redirect.
module merlin_prefetch_ctrl #(
    parameter int unsigned C_FIFO_DEPTH_X = 2,
    parameter logic [31:0] C_RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        fetch_en_i,
    input  logic        pc_load_i,
    input  logic [31:0] pc_load_value_i,
    output logic        ireq_valid_o,
    input  logic        ireq_ready_i,
    output logic [31:0] ireq_addr_o,
    input  logic        iresp_valid_i,
    input  logic [31:0] iresp_rdata_i,
    output logic        fifo_flush_o,
    output logic        fifo_wr_o,
    output logic [63:0] fifo_din_o,
    input  logic        fifo_rd_i
);

    localparam int unsigned W     = C_FIFO_DEPTH_X + 1;
    localparam int unsigned DEPTH = 1 << C_FIFO_DEPTH_X;
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W:0]   DEPTH_V = (W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] req_pc_q;
    logic [31:0] resp_pc_q;
    logic [W-1:0] occupancy_q;
    logic [W-1:0] outstanding_q;
    logic [W-1:0] stale_q;

    logic [W:0]   in_flight;
    logic [W:0]   stale_sum;
    logic [W:0]   stale_sat;
    logic [W-1:0] stale_load;
    logic [31:0]  load_pc;
    logic         resp_stale;
    logic         issue;
    logic         rd_eff;

    assign load_pc   = pc_load_value_i & ~32'h3;
    assign in_flight = {1'b0, occupancy_q} + {1'b0, outstanding_q};

    // Requests are capped so every in-flight response always has a FIFO slot.
    assign ireq_valid_o = (state_q == FETCH) & fetch_en_i & ~pc_load_i & ~reset_i
                        & (in_flight < DEPTH_V);
    assign ireq_addr_o  = {req_pc_q[31:2], 2'b00};
    assign issue        = ireq_valid_o & ireq_ready_i;

    assign resp_stale = (stale_q != '0) | pc_load_i;
    assign fifo_wr_o  = iresp_valid_i & ~resp_stale & ~reset_i;
    assign fifo_din_o = {resp_pc_q, iresp_rdata_i};
    assign fifo_flush_o = pc_load_i | reset_i;
    assign rd_eff     = fifo_rd_i & (occupancy_q != '0);

    // On redirect every outstanding request becomes stale, minus a response
    // consumed in the same cycle; the subtraction saturates at zero.
    assign stale_sum  = {1'b0, stale_q} + {1'b0, outstanding_q};
    assign stale_sat  = (iresp_valid_i && stale_sum != '0) ? stale_sum - (W+1)'(1)
                                                           : stale_sum;
    assign stale_load = stale_sat[W-1:0];

    always_ff @(posedge clk_i) begin
        // NOTE: reset is the first branch so it overrides pc_load_i and all inputs.
        if (reset_i) begin
            state_q       <= IDLE;
            req_pc_q      <= C_RESET_VECTOR;
            resp_pc_q     <= C_RESET_VECTOR;
            occupancy_q   <= '0;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else if (pc_load_i) begin
            req_pc_q      <= load_pc;
            resp_pc_q     <= load_pc;
            occupancy_q   <= '0;
            outstanding_q <= '0;
            stale_q       <= stale_load;
            if (stale_load != '0) state_q <= DRAIN;
            else if (fetch_en_i)  state_q <= FETCH;
            else                  state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (fetch_en_i) state_q <= FETCH;
                FETCH:   if (!fetch_en_i) state_q <= IDLE;
                DRAIN:   if (stale_q == '0) state_q <= fetch_en_i ? FETCH : IDLE;
                default: state_q <= IDLE;
            endcase

            if (issue)     req_pc_q  <= req_pc_q + 32'd4;
            if (fifo_wr_o) resp_pc_q <= resp_pc_q + 32'd4;

            if (iresp_valid_i && stale_q != '0) stale_q <= stale_q - ONE;

            unique case ({fifo_wr_o, rd_eff})
                2'b10:   occupancy_q <= occupancy_q + ONE;
                2'b01:   occupancy_q <= occupancy_q - ONE;
                default: occupancy_q <= occupancy_q;
            endcase

            unique case ({issue, fifo_wr_o})
                2'b10:   outstanding_q <= outstanding_q + ONE;
                2'b01:   outstanding_q <= outstanding_q - ONE;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

endmodule

// File: tb/tb_merlin_prefetch_ctrl.sv
// Directed bench for merlin_prefetch_ctrl (DEPTH = 4, reset vector 0).
module tb_merlin_prefetch_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        fetch_en_i;
    logic        pc_load_i;
    logic [31:0] pc_load_value_i;
    logic        ireq_valid_o;
    logic        ireq_ready_i;
    logic [31:0] ireq_addr_o;
    logic        iresp_valid_i;
    logic [31:0] iresp_rdata_i;
    logic        fifo_flush_o;
    logic        fifo_wr_o;
    logic [63:0] fifo_din_o;
    logic        fifo_rd_i;

    int checks = 0;
    int errors = 0;

    localparam logic [63:0] S_IDLE = 64'd0, S_FETCH = 64'd1, S_DRAIN = 64'd2;

    merlin_prefetch_ctrl dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .fetch_en_i      (fetch_en_i),
        .pc_load_i       (pc_load_i),
        .pc_load_value_i (pc_load_value_i),
        .ireq_valid_o    (ireq_valid_o),
        .ireq_ready_i    (ireq_ready_i),
        .ireq_addr_o     (ireq_addr_o),
        .iresp_valid_i   (iresp_valid_i),
        .iresp_rdata_i   (iresp_rdata_i),
        .fifo_flush_o    (fifo_flush_o),
        .fifo_wr_o       (fifo_wr_o),
        .fifo_din_o      (fifo_din_o),
        .fifo_rd_i       (fifo_rd_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        reset_i = 1'b1; fetch_en_i = 1'b0; pc_load_i = 1'b0; pc_load_value_i = '0;
        ireq_ready_i = 1'b0; iresp_valid_i = 1'b0; iresp_rdata_i = '0; fifo_rd_i = 1'b0;
        #1;
        check("rst_flush", fifo_flush_o, 1);
        check("rst_valid", ireq_valid_o, 0);
        tick();
        reset_i = 1'b0;
        #1;
        check("rst_state", dut.state_q, S_IDLE);
        check("rst_addr", ireq_addr_o, 0);
        check("rst_occ", dut.occupancy_q, 0);
        check("rst_out", dut.outstanding_q, 0);
        check("rst_stale", dut.stale_q, 0);

        // Four requests fill the in-flight budget.
        fetch_en_i = 1'b1; ireq_ready_i = 1'b1;
        #1;
        check("idle_no_req", ireq_valid_o, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("req_valid", ireq_valid_o, 1);
            check("req_addr", ireq_addr_o, 64'(4 * i));
            tick();
        end
        check("req_capped", ireq_valid_o, 0);
        check("out_4", dut.outstanding_q, 4);

        // Four responses land in order with their PCs.
        for (int i = 0; i < 4; i++) begin
            iresp_valid_i = 1'b1; iresp_rdata_i = 32'hA0 + 32'(i);
            #1;
            check("resp_wr", fifo_wr_o, 1);
            check("resp_din", fifo_din_o, {32'(4 * i), 32'hA0 + 32'(i)});
            tick();
        end
        iresp_valid_i = 1'b0;
        #1;
        check("full_occ", dut.occupancy_q, 4);
        check("full_no_req", ireq_valid_o, 0);
        fifo_rd_i = 1'b1;
        tick();
        fifo_rd_i = 1'b0;
        #1;
        check("pop_req", ireq_valid_o, 1);
        check("pop_addr", ireq_addr_o, 64'h10);
        tick();
        check("one_req_only", ireq_valid_o, 0);

        // Occupancy 2: write, pop and issue together.
        ireq_ready_i = 1'b0; fifo_rd_i = 1'b1;
        tick();
        check("occ_2", dut.occupancy_q, 2);
        iresp_valid_i = 1'b1; iresp_rdata_i = 32'hB0; ireq_ready_i = 1'b1;
        #1;
        check("sim_valid", ireq_valid_o, 1);
        check("sim_addr", ireq_addr_o, 64'h14);
        check("sim_wr", fifo_wr_o, 1);
        check("sim_din", fifo_din_o, {32'h10, 32'hB0});
        tick();
        iresp_valid_i = 1'b0; fifo_rd_i = 1'b0; ireq_ready_i = 1'b0;
        #1;
        check("sim_occ", dut.occupancy_q, 2);
        // Issue and write in the same cycle cancel: outstanding stays at 1.
        check("sim_out", dut.outstanding_q, 1);

        // Empty the FIFO, bring outstanding to 3, then redirect.
        fifo_rd_i = 1'b1;
        tick(); tick();
        fifo_rd_i = 1'b0; ireq_ready_i = 1'b1;
        tick(); tick();
        ireq_ready_i = 1'b0;
        #1;
        check("out_3", dut.outstanding_q, 3);
        pc_load_i = 1'b1; pc_load_value_i = 32'h203; ireq_ready_i = 1'b1;
        #1;
        check("load_flush", fifo_flush_o, 1);
        check("load_no_req", ireq_valid_o, 0);
        tick();
        pc_load_i = 1'b0;
        #1;
        check("drain_state", dut.state_q, S_DRAIN);
        check("drain_stale", dut.stale_q, 3);
        check("drain_addr", ireq_addr_o, 64'h200);
        check("drain_no_req", ireq_valid_o, 0);
        for (int i = 0; i < 3; i++) begin
            iresp_valid_i = 1'b1; iresp_rdata_i = 32'hEE;
            #1;
            check("stale_no_wr", fifo_wr_o, 0);
            tick();
        end
        iresp_valid_i = 1'b0;
        #1;
        check("drained_stale", dut.stale_q, 0);
        check("drained_state", dut.state_q, S_DRAIN);
        check("drained_no_req", ireq_valid_o, 0);
        tick();
        check("refetch_valid", ireq_valid_o, 1);
        check("refetch_addr", ireq_addr_o, 64'h200);
        tick();
        ireq_ready_i = 1'b0; iresp_valid_i = 1'b1; iresp_rdata_i = 32'hC0;
        #1;
        check("refetch_wr", fifo_wr_o, 1);
        check("refetch_din", fifo_din_o, {32'h200, 32'hC0});
        tick();
        iresp_valid_i = 1'b0;

        // Redirect coinciding with the only outstanding response.
        ireq_ready_i = 1'b1;
        tick();
        ireq_ready_i = 1'b0;
        pc_load_i = 1'b1; pc_load_value_i = 32'h300; iresp_valid_i = 1'b1;
        #1;
        check("coinc_no_wr", fifo_wr_o, 0);
        tick();
        pc_load_i = 1'b0; iresp_valid_i = 1'b0;
        #1;
        check("coinc_stale", dut.stale_q, 0);
        check("coinc_state", dut.state_q, S_FETCH);
        check("coinc_out", dut.outstanding_q, 0);

        // Address wrap at the top of the space; unaligned target is aligned.
        pc_load_i = 1'b1; pc_load_value_i = 32'hFFFF_FFFE;
        tick();
        pc_load_i = 1'b0;
        #1;
        check("wrap_addr_hi", ireq_addr_o, 64'hFFFF_FFFC);
        ireq_ready_i = 1'b1;
        tick();
        ireq_ready_i = 1'b0;
        #1;
        check("wrap_addr_0", ireq_addr_o, 0);

        // Pop of an empty FIFO is ignored.
        fifo_rd_i = 1'b1;
        tick();
        fifo_rd_i = 1'b0;
        #1;
        check("no_underflow", dut.occupancy_q, 0);

        // FETCH -> IDLE still writes the outstanding response.
        fetch_en_i = 1'b0;
        tick();
        check("idle_state", dut.state_q, S_IDLE);
        iresp_valid_i = 1'b1; iresp_rdata_i = 32'hD0;
        #1;
        check("idle_wr", fifo_wr_o, 1);
        check("idle_din", fifo_din_o, {32'hFFFF_FFFC, 32'hD0});
        tick();
        iresp_valid_i = 1'b0;

        // Reset in the middle of DRAIN, asserted together with a redirect.
        fetch_en_i = 1'b1;
        tick();
        ireq_ready_i = 1'b1;
        tick();
        ireq_ready_i = 1'b0;
        pc_load_i = 1'b1; pc_load_value_i = 32'h400;
        tick();
        check("mid_drain", dut.state_q, S_DRAIN);
        pc_load_i = 1'b1; pc_load_value_i = 32'h800; reset_i = 1'b1;
        #1;
        check("rst2_flush", fifo_flush_o, 1);
        check("rst2_valid", ireq_valid_o, 0);
        tick();
        reset_i = 1'b0; pc_load_i = 1'b0;
        #1;
        check("rst2_state", dut.state_q, S_IDLE);
        check("rst2_stale", dut.stale_q, 0);
        check("rst2_addr", ireq_addr_o, 0);
        check("rst2_valid_idle", ireq_valid_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
